uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
Serial UART transmitter that consumes the byte stream produced by the transmit-side data source over the Tx_EN/Tx_WR/Tx_DATA/Tx_BUSY handshake. It shifts each byte out on TxD as an 11-bit frame: start, 8 data bits LSB first, even parity, stop. The bit rate is chosen by Tx_baud_select. Tx_BUSY is returned to the source for flow control.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz; used to derive the baud divisors.
OVERSAMPLE, 16, number of baud ticks per serial bit.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
Tx_EN  input  1  baud generator enable while idle; does not gate acceptance of a write.
Tx_WR  input  1  write strobe; sampled only in IDLE.
Tx_DATA  input  8  byte to send; Tx_DATA[0] is sent first.
Tx_baud_select  input  3  rate code: 0=300, 1=1200, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200 baud.
TxD  output  1  serial line; idles high.
Tx_BUSY  output  1  high from the capture edge until the stop bit completes.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, TxD=1, Tx_BUSY=0, shift register=0, bit counter=0, baud counter=0, tick counter=0.
- Baud divisor: DIV = round(CLK_FREQ/(OVERSAMPLE*baud)). At 50 MHz the values are 10417, 2604, 651, 326, 163, 81, 54, 27.
- The baud counter pulses a 1-cycle tick every DIV clocks.
- The baud counter runs when Tx_EN=1 or a frame is active. Otherwise it is held at 0.
- Tx_baud_select is latched at capture. Changes during a frame take effect on the next frame.
- Capture: at a clock edge with state=IDLE and Tx_WR=1:
  - latch Tx_DATA and the even parity (XOR of the 8 data bits);
  - clear the baud and tick counters;
  - go to START; Tx_BUSY=1 from this edge.
- Tx_WR=1 in any state other than IDLE is ignored. Data is not queued.
- States and TxD value:
  - IDLE: TxD=1.
  - START: TxD=0.
  - DATA: TxD=shift[0]; shift right on each bit boundary; bit counter runs 0..7.
  - PARITY: TxD=parity.
  - STOP: TxD=1.
- Each state lasts exactly OVERSAMPLE ticks (16*DIV clocks). A bit ends on the 16th tick.
- State transitions: START→DATA; DATA→DATA while bit counter<7; DATA→PARITY after bit 7; PARITY→STOP; STOP→IDLE.
- TxD is registered. It changes on the same edge as the state change, with no glitches.
- Frame length is exactly 11*16*DIV clocks from the capture edge to Tx_BUSY falling.
- Tx_BUSY falls on the edge that ends STOP. If Tx_WR is still 1, the next capture happens on the following edge, so Tx_BUSY is low for exactly 1 cycle between back-to-back frames.
- Reset asserted mid-frame: abort immediately, TxD=1, Tx_BUSY=0. The partial frame is not resumed.
- Counter wrap: the baud counter returns to 0 on a tick; the tick counter wraps 15→0 on a bit boundary. There is no free-running overflow.

Decomposition:
- Shared include file holds:
  - state encoding: IDLE, START, DATA, PARITY, STOP (one-hot or 3-bit binary);
  - FRAME_BITS=11 and OVERSAMPLE;
  - the 8-entry baud divisor table as a function of CLK_FREQ.
- Sub-module baud_controller: inputs clk, reset, enable, clear, baud_select[2:0]; output sample_tick. It contains the divisor mux and the counter.
- The frame FSM, shift register and parity logic stay in uart_transmitter.

Test Plan:
- Reset check: hold reset=0 for 5 cycles, with Tx_WR=1 mid-reset → TxD=1, Tx_BUSY=0 throughout; no capture occurs.
- Single frame, sel=7, 50 MHz: write 0x89 with a 1-cycle Tx_WR → TxD = 0,1,0,0,1,0,0,0,1,1(parity),1(stop); each bit lasts 432 clocks; Tx_BUSY high for exactly 4752 clocks.
- Back-to-back writes: hold Tx_WR=1, present 0x55 then 0xCC → two frames; parity bits are 0 and 0; Tx_BUSY low for exactly 1 cycle between frames; second frame bits are 0,0,0,1,1,0,0,1,1,0,1.
- Write while busy: pulse Tx_WR with 0xAA at cycle 1000 of a 0x89 frame → the frame is unchanged; no second frame; Tx_BUSY falls at 4752.
- Rate change: send 0xFF at sel=0 and change sel to 7 mid-frame → every bit lasts 166672 clocks, parity=0; the next frame uses 432-clock bits.
- Reset mid-frame: assert reset at clock 2000 of a frame → TxD=1 and Tx_BUSY=0 immediately, without waiting for a clock edge; a new write after release produces a full, correct frame.

Source files
------------

// File: rtl/uart_transmitter_pkg.sv
// Shared definitions for the UART transmitter: frame state encoding, framing
// constants and the baud divisor table derived from the system clock frequency.
package uart_transmitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int FRAME_BITS         = 11;
    localparam int DATA_BITS          = 8;
    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int DIV_W              = 24;

    function automatic int unsigned baud_rate(input logic [2:0] sel);
        int unsigned rate;
        case (sel)
            3'd0:    rate = 32'd300;
            3'd1:    rate = 32'd1200;
            3'd2:    rate = 32'd4800;
            3'd3:    rate = 32'd9600;
            3'd4:    rate = 32'd19200;
            3'd5:    rate = 32'd38400;
            3'd6:    rate = 32'd57600;
            default: rate = 32'd115200;
        endcase
        return rate;
    endfunction

    // Rounded clocks-per-tick; never below one so the tick stays well defined.
    function automatic logic [DIV_W-1:0] baud_divisor(input longint clk_freq,
                                                      input longint oversample,
                                                      input logic [2:0] sel);
        longint den;
        longint quo;
        den = oversample * longint'(baud_rate(sel));
        quo = (clk_freq + den / 64'sd2) / den;
        if (quo < 64'sd1) begin
            quo = 64'sd1;
        end else begin
            quo = quo;
        end
        return DIV_W'(quo);
    endfunction

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_transmitter_baud_controller.sv
// Baud tick generator: selects the divisor for the latched rate code and pulses
// sample_tick for one clock every DIV clocks while enabled.
module uart_transmitter_baud_controller
    import uart_transmitter_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       clear,
    input  logic [2:0] baud_select,
    output logic       sample_tick
);

    localparam logic [DIV_W-1:0] DIV_0 = baud_divisor(CLK_FREQ, OVERSAMPLE, 3'd0);
    localparam logic [DIV_W-1:0] DIV_1 = baud_divisor(CLK_FREQ, OVERSAMPLE, 3'd1);
    localparam logic [DIV_W-1:0] DIV_2 = baud_divisor(CLK_FREQ, OVERSAMPLE, 3'd2);
    localparam logic [DIV_W-1:0] DIV_3 = baud_divisor(CLK_FREQ, OVERSAMPLE, 3'd3);
    localparam logic [DIV_W-1:0] DIV_4 = baud_divisor(CLK_FREQ, OVERSAMPLE, 3'd4);
    localparam logic [DIV_W-1:0] DIV_5 = baud_divisor(CLK_FREQ, OVERSAMPLE, 3'd5);
    localparam logic [DIV_W-1:0] DIV_6 = baud_divisor(CLK_FREQ, OVERSAMPLE, 3'd6);
    localparam logic [DIV_W-1:0] DIV_7 = baud_divisor(CLK_FREQ, OVERSAMPLE, 3'd7);

    logic [DIV_W-1:0] div_s;
    logic [DIV_W-1:0] cnt_r;
    logic             tick_s;

    // Divisor mux over the constant rate table.
    always_comb begin
        case (baud_select)
            3'd0:    div_s = DIV_0;
            3'd1:    div_s = DIV_1;
            3'd2:    div_s = DIV_2;
            3'd3:    div_s = DIV_3;
            3'd4:    div_s = DIV_4;
            3'd5:    div_s = DIV_5;
            3'd6:    div_s = DIV_6;
            default: div_s = DIV_7;
        endcase
    end

    assign tick_s      = enable && !clear && (cnt_r == (div_s - DIV_W'(1)));
    assign sample_tick = tick_s;

    // Clock divider: restarts on clear, on a tick, and whenever disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (clear || !enable || tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: captures a byte on Tx_WR while idle and sends it as
// start, 8 data bits LSB first, even parity and stop, with registered TxD.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    input  logic [7:0] Tx_DATA,
    input  logic [2:0] Tx_baud_select,
    output logic       TxD,
    output logic       Tx_BUSY
);

    localparam int                TICK_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_t         state_r;
    tx_state_t         state_next_s;
    logic [7:0]        shift_r;
    logic [7:0]        shift_next_s;
    logic              parity_r;
    logic              parity_next_s;
    logic [2:0]        bit_cnt_r;
    logic [2:0]        bit_cnt_next_s;
    logic [2:0]        sel_r;
    logic [2:0]        sel_next_s;
    logic              busy_r;
    logic              busy_next_s;
    logic              txd_r;
    logic              txd_next_s;
    logic [TICK_W-1:0] tick_cnt_r;
    logic              capture_s;
    logic              baud_en_s;
    logic              tick_s;
    logic              bit_end_s;

    assign capture_s = (state_r == ST_IDLE) && Tx_WR;
    assign baud_en_s = Tx_EN || (state_r != ST_IDLE);
    assign bit_end_s = tick_s && (tick_cnt_r == TICK_LAST) && (state_r != ST_IDLE);

    uart_transmitter_baud_controller #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud (
        .clk         (clk),
        .reset       (reset),
        .enable      (baud_en_s),
        .clear       (capture_s),
        .baud_select (sel_r),
        .sample_tick (tick_s)
    );

    // Frame sequencing: capture, bit boundaries and the data shift.
    always_comb begin
        state_next_s   = state_r;
        shift_next_s   = shift_r;
        parity_next_s  = parity_r;
        bit_cnt_next_s = bit_cnt_r;
        sel_next_s     = sel_r;
        busy_next_s    = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (Tx_WR) begin
                    state_next_s   = ST_START;
                    shift_next_s   = Tx_DATA;
                    parity_next_s  = even_parity(Tx_DATA);
                    bit_cnt_next_s = 3'd0;
                    sel_next_s     = Tx_baud_select;
                    busy_next_s    = 1'b1;
                end else begin
                    busy_next_s    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_next_s   = ST_DATA;
                    bit_cnt_next_s = 3'd0;
                end else begin
                    state_next_s   = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_next_s = {1'b0, shift_r[7:1]};
                    if (bit_cnt_r == BIT_LAST) begin
                        state_next_s = ST_PARITY;
                    end else begin
                        bit_cnt_next_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_next_s = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    state_next_s = ST_IDLE;
                    busy_next_s  = 1'b0;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // Line level for the state being entered, so TxD flips with the state.
    always_comb begin
        case (state_next_s)
            ST_IDLE:   txd_next_s = 1'b1;
            ST_START:  txd_next_s = 1'b0;
            ST_DATA:   txd_next_s = shift_next_s[0];
            ST_PARITY: txd_next_s = parity_next_s;
            ST_STOP:   txd_next_s = 1'b1;
            default:   txd_next_s = 1'b1;
        endcase
    end

    // Frame state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            shift_r   <= 8'h00;
            parity_r  <= 1'b0;
            bit_cnt_r <= 3'd0;
            sel_r     <= 3'd0;
            busy_r    <= 1'b0;
            txd_r     <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            shift_r   <= shift_next_s;
            parity_r  <= parity_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            sel_r     <= sel_next_s;
            busy_r    <= busy_next_s;
            txd_r     <= txd_next_s;
        end
    end

    // Ticks within the current bit; wraps on the bit boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt_r <= '0;
        end else if (capture_s || (state_r == ST_IDLE)) begin
            tick_cnt_r <= '0;
        end else if (tick_s) begin
            tick_cnt_r <= (tick_cnt_r == TICK_LAST) ? '0 : tick_cnt_r + TICK_W'(1);
        end else begin
            tick_cnt_r <= tick_cnt_r;
        end
    end

    assign TxD     = txd_r;
    assign Tx_BUSY = busy_r;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed and randomized checks of uart_transmitter against a bit-level frame
// model (expected line level and busy flag as a function of time since capture).
module tb_uart_transmitter;

    localparam int CLK_FREQ = 1_000_000;
    localparam int OS       = 16;
    localparam int NBITS    = 11;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       tx_en   = 1'b0;
    logic       tx_wr   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [2:0] tx_sel  = 3'd0;
    logic       txd;
    logic       tx_busy;

    int vectors     = 0;
    int miscompares = 0;

    uart_transmitter #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OS)) dut (
        .clk            (clk),
        .reset          (reset),
        .Tx_EN          (tx_en),
        .Tx_WR          (tx_wr),
        .Tx_DATA        (tx_data),
        .Tx_baud_select (tx_sel),
        .TxD            (txd),
        .Tx_BUSY        (tx_busy)
    );

    always #5 clk = ~clk;

    // Clocks per serial bit: OVERSAMPLE * round(CLK_FREQ / (OVERSAMPLE * baud)).
    function automatic int bit_len(input int sel);
        real baud;
        int  d;
        case (sel)
            0:       baud = 300.0;
            1:       baud = 1200.0;
            2:       baud = 4800.0;
            3:       baud = 9600.0;
            4:       baud = 19200.0;
            5:       baud = 38400.0;
            6:       baud = 57600.0;
            default: baud = 115200.0;
        endcase
        d = $rtoi(real'(CLK_FREQ) / (real'(OS) * baud) + 0.5);
        if (d < 1) d = 1;
        return OS * d;
    endfunction

    // Level of frame bit k: start, data LSB first, even parity, stop.
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9) return (ones % 2 == 1);
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, req);
        end
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_txd[%0d]", tag, i), txd, 1'b1);
            chk($sformatf("%s_busy[%0d]", tag, i), tx_busy, 1'b0);
        end
    endtask

    task automatic start_write(input logic [7:0] d, input int sel);
        @(negedge clk);
        tx_data = d;
        tx_sel  = 3'(sel);
        tx_wr   = 1'b1;
    endtask

    // Follows one frame from the cycle after capture. act: 0 none, 1 write
    // pulse of aval, 2 rate change to aval, 3 reset assertion, 4 new data with
    // Tx_WR kept high.
    task automatic check_frame(input logic [7:0] d, input int sel, input int act,
                               input int at, input logic [7:0] aval, input string tag);
        int len;
        len = bit_len(sel);
        @(negedge clk);
        for (int t = 0; t <= NBITS * len; t++) begin
            if (t > 0) @(negedge clk);
            if (t == 0 && act != 4) tx_wr = 1'b0;
            if (act == 1 && t == at + 1) tx_wr = 1'b0;
            if (t == NBITS * len) begin
                chk($sformatf("%s_end_txd", tag), txd, 1'b1);
                chk($sformatf("%s_end_busy", tag), tx_busy, 1'b0);
            end else if ((t % len == 0) || (t % len == len - 1)) begin
                chk($sformatf("%s_txd_t%0d", tag, t), txd, frame_bit(d, t / len));
                chk($sformatf("%s_busy_t%0d", tag, t), tx_busy, 1'b1);
            end
            if (t == at) begin
                case (act)
                    1: begin tx_wr = 1'b1; tx_data = aval; end
                    2: tx_sel = aval[2:0];
                    3: begin
                        #1 reset = 1'b0;
                        #1;
                        chk($sformatf("%s_rst_txd", tag), txd, 1'b1);
                        chk($sformatf("%s_rst_busy", tag), tx_busy, 1'b0);
                        return;
                    end
                    4: tx_data = aval;
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        logic [7:0] rd;
        int         rs;

        // Reset held low with a write strobe in the middle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) begin tx_wr = 1'b1; tx_data = 8'h89; end
            chk($sformatf("rst_txd[%0d]", i), txd, 1'b1);
            chk($sformatf("rst_busy[%0d]", i), tx_busy, 1'b0);
        end
        @(negedge clk);
        tx_wr = 1'b0;
        reset = 1'b1;
        idle_check(4, "post_rst");

        // Single frame at the fastest rate.
        tx_en = 1'b1;
        start_write(8'h89, 7);
        check_frame(8'h89, 7, 0, -1, 8'h00, "single");
        idle_check(3, "single_idle");

        // Back-to-back frames with Tx_WR held high.
        start_write(8'h55, 3);
        check_frame(8'h55, 3, 4, 0, 8'hCC, "b2b_a");
        check_frame(8'hCC, 3, 0, -1, 8'h00, "b2b_b");
        idle_check(3, "b2b_idle");

        // Write while busy is ignored and not queued.
        tx_en = 1'b0;
        start_write(8'h89, 2);
        check_frame(8'h89, 2, 1, 1000, 8'hAA, "wbusy");
        idle_check(2 * bit_len(2), "wbusy_idle");

        // Rate code change mid-frame applies to the next frame only.
        start_write(8'hFF, 0);
        check_frame(8'hFF, 0, 2, 500, 8'd7, "rate_a");
        start_write(8'h3C, 7);
        check_frame(8'h3C, 7, 0, -1, 8'h00, "rate_b");

        // Reset mid-frame aborts; a new write sends a full frame.
        start_write(8'hA5, 2);
        check_frame(8'hA5, 2, 3, 2000, 8'h00, "abort");
        tx_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort_hold_txd[%0d]", i), txd, 1'b1);
            chk($sformatf("abort_hold_busy[%0d]", i), tx_busy, 1'b0);
        end
        reset = 1'b1;
        idle_check(2, "abort_rel");
        start_write(8'h5A, 2);
        check_frame(8'h5A, 2, 0, -1, 8'h00, "after_abort");

        // Random bytes, rates, enables and idle gaps.
        for (int n = 0; n < 8; n++) begin
            rd    = 8'($urandom);
            rs    = int'($urandom_range(2, 7));
            tx_en = 1'($urandom);
            idle_check(int'($urandom_range(0, 5)), $sformatf("rnd%0d_gap", n));
            start_write(rd, rs);
            check_frame(rd, rs, 0, -1, 8'h00, $sformatf("rnd%0d", n));
        end
        idle_check(2, "final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
